// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: data-memory req/ack access, load formatting, stall and error flags
//
// Issues at most one data-memory access per instruction over a req/ack bus. The pipeline is
// held with stall while the access runs, and the loaded word is formatted by size and sign.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   valid_in          EX/MEM holds a real instruction
//   PC, ALU_result    from EX/MEM; ALU_result is the load/store address
//   store_data        store operand (rt)
//   RF_rd, MemtoReg, RegWrite, PCSrc   writeback/next-PC control from EX/MEM
//   MemRead, MemWrite, MemSize, MemSigned   memory operation descriptor
//   stall             hold PC, IF/ID, ID/EX, EX/MEM
//   dmem_*            data-memory bus (req/we/addr/wdata/be out, ack/rdata in)
//   *_out, Mem_data   MEM/WB inputs (Mem_data is the formatted load value)
//   align_err, bus_err   one-cycle error pulses
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] PC,
    input  logic [31:0] ALU_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  RF_rd,
    input  logic [1:0]  MemtoReg,
    input  logic        RegWrite,
    input  logic [2:0]  PCSrc,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] ALU_result_out,
    output logic [4:0]  RF_rd_out,
    output logic [1:0]  MemtoReg_out,
    output logic [2:0]  PCSrc_out,
    output logic [31:0] Mem_data,
    output logic        RegWrite_out,
    output logic        align_err,
    output logic        bus_err
);
    // Next-PC select meaning "PC + 4"; used as the bubble value toward MEM/WB.
    localparam logic [2:0] NPC_PLUS4 = 3'b000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             err;
    logic [29:0]      addr_q;
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [31:0]      mem_data_q;

    logic        mem_op, misalign, start, terminal;
    logic        is_idle, is_busy, is_done;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    // MemSize 2'b11 is treated as a word access.
    always_comb begin
        mem_op   = valid_in & (MemRead | MemWrite);
        misalign = (MemSize == 2'b01 & ALU_result[0]) | (MemSize[1] & (ALU_result[1:0] != 2'b00));
        is_idle  = (state == IDLE);
        is_busy  = (state == BUSY);
        is_done  = (state == DONE);
        start    = is_idle & mem_op & !misalign;
        terminal = (counter == CNT_W'(TIMEOUT_CYCLES - 1));

        be_next    = 4'b0001 << ALU_result[1:0];
        wdata_next = {4{store_data[7:0]}};
        if (MemSize[1]) begin
            be_next    = 4'b1111;
            wdata_next = store_data;
        end else if (MemSize[0]) begin
            be_next    = ALU_result[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{store_data[15:0]}};
        end
    end

    // Load lane extraction is driven by the latched address/size so it is stable while BUSY.
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (size_q[1])
            load_fmt = dmem_rdata;
        else if (size_q[0])
            load_fmt = {{16{signed_q & half_sel[15]}}, half_sel};
        else
            load_fmt = {{24{signed_q & byte_sel[7]}}, byte_sel};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            counter    <= '0;
            err        <= 1'b0;
            addr_q     <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            mem_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q   <= ALU_result[31:2];
                        lane_q   <= ALU_result[1:0];
                        size_q   <= MemSize;
                        signed_q <= MemSigned;
                        we_q     <= MemWrite;
                        be_q     <= be_next;
                        wdata_q  <= wdata_next;
                        counter  <= '0;
                        err      <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    counter <= counter + 1'b1;
                    // An ack on the terminal-count cycle still completes normally.
                    if (dmem_ack) begin
                        mem_data_q <= we_q ? 32'h0 : load_fmt;
                        state      <= DONE;
                    end else if (terminal) begin
                        mem_data_q <= 32'h0;
                        err        <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    counter <= '0;
                    err     <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Control outputs are forced to their reset values while rst is low, independent of inputs.
    always_comb begin
        stall          = rst & (start | is_busy);
        dmem_req       = is_busy;
        dmem_we        = is_busy & we_q;
        dmem_be        = is_busy ? be_q : 4'b0000;
        dmem_addr      = {addr_q, 2'b00};
        dmem_wdata     = wdata_q;
        PC_out         = PC;
        ALU_result_out = ALU_result;
        RF_rd_out      = RF_rd;
        MemtoReg_out   = MemtoReg;
        PCSrc_out      = (!rst | start | is_busy) ? NPC_PLUS4 : PCSrc;
        Mem_data       = is_done ? mem_data_q : 32'h0;
        RegWrite_out   = 1'b0;
        if (rst) begin
            if (is_idle)
                RegWrite_out = RegWrite & !mem_op;
            else if (is_done)
                RegWrite_out = RegWrite & !err;
        end
        align_err      = rst & is_idle & mem_op & misalign;
        bus_err        = rst & is_busy & !dmem_ack & terminal;
    end
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
module tb_mem_access;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] PC, ALU_result, store_data;
    logic [4:0]  RF_rd;
    logic [1:0]  MemtoReg;
    logic        RegWrite;
    logic [2:0]  PCSrc;
    logic        MemRead, MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] PC_out, ALU_result_out;
    logic [4:0]  RF_rd_out;
    logic [1:0]  MemtoReg_out;
    logic [2:0]  PCSrc_out;
    logic [31:0] Mem_data;
    logic        RegWrite_out, align_err, bus_err;

    int checks = 0;
    int failures = 0;

    mem_access #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .PC(PC), .ALU_result(ALU_result),
        .store_data(store_data), .RF_rd(RF_rd), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .PCSrc(PCSrc), .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
        .MemSigned(MemSigned), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .PC_out(PC_out),
        .ALU_result_out(ALU_result_out), .RF_rd_out(RF_rd_out), .MemtoReg_out(MemtoReg_out),
        .PCSrc_out(PCSrc_out), .Mem_data(Mem_data), .RegWrite_out(RegWrite_out),
        .align_err(align_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sd;
        logic [1:0]  size;
        logic        sgn;
        logic        wr;
        logic        rw;
        logic [31:0] rdata;
        int          ackd;
        logic [31:0] exp_mem;
        logic [31:0] exp_be;
        logic [31:0] exp_wdata;
        logic        exp_rwo;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-lane arithmetic straight from the little-endian lane rules.
    function automatic logic [31:0] model_be(input logic [31:0] a, input logic [1:0] sz);
        int lane = a % 4;
        if (sz == 2'd2) return 32'hF;
        if (sz == 2'd1) return 32'h3 << lane;
        return 32'h1 << lane;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] sd, input logic [1:0] sz);
        if (sz == 2'd2) return sd;
        if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
        return (sd & 32'hFF) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] sz, input logic sgn);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        if (sz == 2'd2) return rd;
        if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = v & 32'hFF;
            if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end
        return v;
    endfunction

    task automatic set_idle();
        valid_in = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        dmem_ack = 1'b0;
    endtask

    // Called just after a rising edge. ackd = BUSY cycle carrying the ack (>TO: never acked).
    task automatic run_mem(input logic [31:0] addr, input logic [31:0] sd, input logic [1:0] size,
                           input logic sgn, input logic wr, input logic rw, input logic [31:0] rdata,
                           input int ackd, input logic [31:0] exp_mem, input logic [31:0] exp_be,
                           input logic [31:0] exp_wdata, input logic exp_rwo);
        int  n;
        logic to;
        to = (ackd > TO);
        n  = to ? TO : ackd;
        valid_in = 1'b1; ALU_result = addr; store_data = sd; MemSize = size; MemSigned = sgn;
        MemRead = !wr; MemWrite = wr; RegWrite = rw; PC = $urandom; PCSrc = 3'b101;
        RF_rd = 5'($urandom); MemtoReg = 2'($urandom); dmem_ack = 1'b0;
        @(negedge clk);
        chk("issue_stall", stall, 1);
        chk("issue_req", dmem_req, 0);
        chk("issue_regwrite", RegWrite_out, 0);
        chk("issue_pcsrc", PCSrc_out, 0);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            dmem_ack   = (c == ackd);
            dmem_rdata = (c == ackd) ? rdata : $urandom;
            @(negedge clk);
            chk("busy_req", dmem_req, 1);
            chk("busy_stall", stall, 1);
            chk("busy_we", dmem_we, wr);
            chk("busy_addr", dmem_addr, {addr[31:2], 2'b00});
            chk("busy_be", dmem_be, exp_be);
            if (wr) chk("busy_wdata", dmem_wdata, exp_wdata);
            chk("busy_regwrite", RegWrite_out, 0);
            chk("busy_pcsrc", PCSrc_out, 0);
            chk("busy_bus_err", bus_err, to && (c == n));
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("done_stall", stall, 0);
        chk("done_req", dmem_req, 0);
        chk("done_mem_data", Mem_data, exp_mem);
        chk("done_regwrite", RegWrite_out, exp_rwo);
        chk("done_pcsrc", PCSrc_out, 3'b101);
        chk("done_bus_err", bus_err, 0);
        @(posedge clk); #1;
        set_idle();
    endtask

    task automatic run_misalign(input logic [31:0] addr, input logic [1:0] size, input logic wr);
        valid_in = 1'b1; ALU_result = addr; MemSize = size; MemSigned = 1'b0;
        MemRead = !wr; MemWrite = wr; RegWrite = 1'b1; PCSrc = 3'b010;
        @(negedge clk);
        chk("mis_align_err", align_err, 1);
        chk("mis_stall", stall, 0);
        chk("mis_req", dmem_req, 0);
        chk("mis_regwrite", RegWrite_out, 0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        chk("mis_pulse_end", align_err, 0);
        chk("mis_no_req", dmem_req, 0);
        @(posedge clk); #1;
    endtask

    // Non-memory cycle; a stray ack must be ignored.
    task automatic run_pass();
        valid_in = 1'($urandom); MemRead = !valid_in; MemWrite = 1'b0;
        PC = $urandom; ALU_result = $urandom; RF_rd = 5'($urandom); MemtoReg = 2'($urandom);
        RegWrite = 1'($urandom); PCSrc = 3'($urandom); MemSize = 2'd2;
        dmem_ack = 1'($urandom); dmem_rdata = $urandom;
        @(negedge clk);
        chk("pass_stall", stall, 0);
        chk("pass_req", dmem_req, 0);
        chk("pass_pc", PC_out, PC);
        chk("pass_alu", ALU_result_out, ALU_result);
        chk("pass_rd", RF_rd_out, RF_rd);
        chk("pass_memtoreg", MemtoReg_out, MemtoReg);
        chk("pass_pcsrc", PCSrc_out, PCSrc);
        chk("pass_regwrite", RegWrite_out, RegWrite);
        chk("pass_mem_data", Mem_data, 0);
        chk("pass_align_err", align_err, 0);
        @(posedge clk); #1;
        set_idle();
    endtask

    initial begin
        tv[0]  = '{32'h100, 32'h0,      2'd2, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 2,  32'hDEADBEEF, 32'hF, 32'h0,        1'b1};
        tv[1]  = '{32'h103, 32'h0,      2'd0, 1'b1, 1'b0, 1'b1, 32'h80112233, 1,  32'hFFFFFF80, 32'h8, 32'h0,        1'b1};
        tv[2]  = '{32'h103, 32'h0,      2'd0, 1'b0, 1'b0, 1'b1, 32'h80112233, 3,  32'h00000080, 32'h8, 32'h0,        1'b1};
        tv[3]  = '{32'h102, 32'hABCD,   2'd1, 1'b0, 1'b1, 1'b0, 32'h0,        1,  32'h0,        32'hC, 32'hABCDABCD, 1'b0};
        tv[4]  = '{32'h102, 32'h0,      2'd1, 1'b1, 1'b0, 1'b1, 32'h80011234, 2,  32'hFFFF8001, 32'hC, 32'h0,        1'b1};
        tv[5]  = '{32'h100, 32'h0,      2'd1, 1'b0, 1'b0, 1'b1, 32'h8001F234, 1,  32'h0000F234, 32'h3, 32'h0,        1'b1};
        tv[6]  = '{32'h101, 32'hA5,     2'd0, 1'b0, 1'b1, 1'b0, 32'h0,        4,  32'h0,        32'h2, 32'hA5A5A5A5, 1'b0};
        tv[7]  = '{32'h200, 32'hCAFEF00D, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0,      1,  32'h0,        32'hF, 32'hCAFEF00D, 1'b0};
        tv[8]  = '{32'h104, 32'h0,      2'd2, 1'b1, 1'b0, 1'b1, 32'h80000000, 1,  32'h80000000, 32'hF, 32'h0,        1'b1};
        tv[9]  = '{32'h101, 32'h0,      2'd0, 1'b0, 1'b0, 1'b1, 32'h00007F00, 16, 32'h0000007F, 32'h2, 32'h0,        1'b1};
        tv[10] = '{32'h108, 32'h0,      2'd2, 1'b0, 1'b0, 1'b1, 32'h12345678, 17, 32'h0,        32'hF, 32'h0,        1'b0};
        tv[11] = '{32'h102, 32'h0,      2'd0, 1'b1, 1'b0, 1'b1, 32'h00AB0000, 5,  32'hFFFFFFAB, 32'h4, 32'h0,        1'b1};

        // Reset with a load presented: everything must read as reset values.
        rst = 1'b0; valid_in = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'd2;
        MemSigned = 1'b0; ALU_result = 32'h100; store_data = 0; PC = 0; RF_rd = 0;
        MemtoReg = 0; RegWrite = 1'b1; PCSrc = 3'b111; dmem_ack = 1'b1; dmem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_mem_data", Mem_data, 0);
        chk("rst_regwrite", RegWrite_out, 0);
        chk("rst_pcsrc", PCSrc_out, 0);
        chk("rst_errs", {align_err, bus_err}, 0);
        set_idle();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run_mem(tv[i].addr, tv[i].sd, tv[i].size, tv[i].sgn, tv[i].wr, tv[i].rw, tv[i].rdata,
                    tv[i].ackd, tv[i].exp_mem, tv[i].exp_be, tv[i].exp_wdata, tv[i].exp_rwo);

        run_misalign(32'h101, 2'd2, 1'b0);
        run_misalign(32'h103, 2'd1, 1'b0);
        run_misalign(32'h102, 2'd2, 1'b1);
        run_misalign(32'h101, 2'd1, 1'b1);

        for (int i = 0; i < 6; i++) run_pass();

        for (int i = 0; i < 30; i++) begin
            logic [1:0]  sz;
            logic [31:0] a, sd, rd;
            logic        wr, sg;
            int          d;
            sz = 2'($urandom_range(0, 2));
            a  = $urandom;
            a  = (sz == 2'd2) ? (a & ~32'h3) : (sz == 2'd1) ? (a & ~32'h1) : a;
            sd = $urandom; rd = $urandom;
            wr = 1'($urandom); sg = 1'($urandom);
            d  = $urandom_range(1, TO + 2);
            run_mem(a, sd, sz, sg, wr, !wr, rd, d,
                    (wr || d > TO) ? 32'h0 : model_load(rd, a, sz, sg),
                    model_be(a, sz), model_wdata(sd, sz), !wr && d <= TO);
            if (i % 5 == 0) run_pass();
        end

        // Reset during BUSY: request and stall drop at once, ack afterwards is ignored.
        valid_in = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'd2;
        ALU_result = 32'h300; RegWrite = 1'b1; PCSrc = 3'b101;
        repeat (3) @(posedge clk);
        #1;
        chk("midbusy_req_before", dmem_req, 1);
        rst = 1'b0;
        #1;
        chk("midbusy_req", dmem_req, 0);
        chk("midbusy_stall", stall, 0);
        chk("midbusy_regwrite", RegWrite_out, 0);
        chk("midbusy_pcsrc", PCSrc_out, 0);
        set_idle();
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req", dmem_req, 0);
        chk("post_rst_mem_data", Mem_data, 0);
        @(posedge clk); #1;
        run_pass();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
